// File: rtl/noc_output_arbiter.sv
// Round-robin, packet-locked output arbiter for a NoC router port. Pop to out_valid is one cycle.
// Pops stall while the output register is full and out_ready is low; stray BODY/TAIL flits are dropped with err_o.
module noc_output_arbiter #(
  parameter int NUM_IN = 5,
  parameter int WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_shift,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  input  logic                    out_ready,
  output logic                    err_o
);
  localparam int PW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;
  localparam logic [PW-1:0] LAST  = PW'(NUM_IN - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     owner;
  logic [PW-1:0]     cand;
  logic [PW-1:0]     sel;
  logic [PW-1:0]     sel_next;
  logic              cand_vld;
  logic              load_ok;
  logic              take;
  logic [WIDTH-1:0]  flit;
  logic [1:0]        ftype;
  int                idx;

  // Scan from the farthest port back to rr_ptr so the closest valid port wins.
  always_comb begin
    cand_vld = 1'b0;
    cand     = '0;
    idx      = 0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (in_valid[idx]) begin
        cand_vld = 1'b1;
        cand     = PW'(idx);
      end
    end
  end

  always_comb begin
    load_ok  = !out_valid || out_ready;
    sel      = (state == LOCKED) ? owner : cand;
    take     = rst_n && load_ok && ((state == LOCKED) ? in_valid[sel] : cand_vld);
    in_shift = '0;
    if (take) in_shift[sel] = 1'b1;
    flit     = in_data[int'(sel)*WIDTH +: WIDTH];
    ftype    = flit[WIDTH-1 -: 2];
    sel_next = (sel == LAST) ? '0 : sel + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err_o     <= 1'b0;
    end else begin
      err_o <= 1'b0;
      if (out_ready) out_valid <= 1'b0;
      if (take) begin
        if (state == IDLE) begin
          case (ftype)
            T_HEAD: begin
              out_valid <= 1'b1;
              out_data  <= flit;
              owner     <= sel;
              state     <= LOCKED;
            end
            T_SINGLE: begin
              out_valid <= 1'b1;
              out_data  <= flit;
              rr_ptr    <= sel_next;
            end
            default: begin
              err_o  <= 1'b1;
              rr_ptr <= sel_next;
            end
          endcase
        end else begin
          out_valid <= 1'b1;
          out_data  <= flit;
          if (ftype == T_TAIL) begin
            state  <= IDLE;
            rr_ptr <= sel_next;
          end else if (ftype != T_BODY) begin
            err_o <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_noc_output_arbiter.sv
// Bench for noc_output_arbiter: directed vector table, hand-written corner sequences, then random traffic vs a reference model.
module tb_noc_output_arbiter;
  localparam int N = 5;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_shift;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic           err_o;

  noc_output_arbiter #(.NUM_IN(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_shift(in_shift), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pd(input int p, input logic [W-1:0] f);
    logic [N*W-1:0] r;
    r = '0;
    r[p*W +: W] = f;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [N-1:0]   iv;
    logic [N*W-1:0] dat;
    logic           rdy;
    logic [N-1:0]   shift;
    logic           vld;
    logic [W-1:0]   odat;
    logic           err;
  } vec_t;

  vec_t tbl[$];

  task automatic run_vec(input vec_t v, input string name);
    in_valid  = v.iv;
    in_data   = v.dat;
    out_ready = v.rdy;
    #1;
    chk({name, "_shift"}, 32'(in_shift), 32'(v.shift));
    tick();
    chk({name, "_vld"}, 32'(out_valid), 32'(v.vld));
    chk({name, "_dat"}, 32'(out_data), 32'(v.odat));
    chk({name, "_err"}, 32'(err_o), 32'(v.err));
  endtask

  // Reference model: owner = -1 means no packet is open; priority is distance from ptr modulo N.
  int          m_owner;
  int          m_ptr;
  logic        m_vld;
  logic [W-1:0] m_dat;
  logic        m_err;

  function automatic int m_grant();
    int best;
    int bd;
    best = -1;
    bd   = N;
    if (m_vld && !out_ready) return -1;
    if (m_owner >= 0) return in_valid[m_owner] ? m_owner : -1;
    for (int i = 0; i < N; i++) begin
      if (in_valid[i] && ((i - m_ptr + N) % N) < bd) begin
        bd   = (i - m_ptr + N) % N;
        best = i;
      end
    end
    return best;
  endfunction

  task automatic m_step(input int g);
    logic [W-1:0] f;
    logic [1:0]   t;
    m_err = 1'b0;
    if (out_ready) m_vld = 1'b0;
    if (g >= 0) begin
      f = in_data[g*W +: W];
      t = f[W-1 -: 2];
      if (m_owner < 0) begin
        if (t == 2'b01) begin
          m_vld = 1'b1; m_dat = f; m_owner = g;
        end else if (t == 2'b11) begin
          m_vld = 1'b1; m_dat = f; m_ptr = (g + 1) % N;
        end else begin
          m_err = 1'b1; m_ptr = (g + 1) % N;
        end
      end else begin
        m_vld = 1'b1; m_dat = f;
        if (t == 2'b10) begin
          m_owner = -1; m_ptr = (g + 1) % N;
        end else if (t != 2'b00) begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  initial begin
    in_valid  = '1;
    in_data   = {N{16'hC123}};
    out_ready = 1'b1;
    #12;
    chk("rst_shift", 32'(in_shift), 32'h0);
    chk("rst_vld", 32'(out_valid), 32'h0);
    chk("rst_dat", 32'(out_data), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    tick();
    rst_n = 1'b1;

    // SINGLE service, alternation between ports 0/3, then a 3-flit packet on port 1 with port 0 waiting.
    tbl.push_back('{5'b00100, pd(2, 16'hC0A5), 1'b1, 5'b00100, 1'b1, 16'hC0A5, 1'b0});
    tbl.push_back('{5'b00000, '0,              1'b1, 5'b00000, 1'b0, 16'hC0A5, 1'b0});
    tbl.push_back('{5'b10000, pd(4, 16'hC004), 1'b1, 5'b10000, 1'b1, 16'hC004, 1'b0});
    for (int r = 0; r < 4; r++)
      tbl.push_back('{5'b01001, pd(0, 16'hC100) | pd(3, 16'hC300), 1'b1,
                      (r % 2 == 0) ? 5'b00001 : 5'b01000, 1'b1,
                      (r % 2 == 0) ? 16'hC100 : 16'hC300, 1'b0});
    tbl.push_back('{5'b00001, pd(0, 16'hC100), 1'b1, 5'b00001, 1'b1, 16'hC100, 1'b0});
    tbl.push_back('{5'b00011, pd(0, 16'hC100) | pd(1, 16'h4001), 1'b1, 5'b00010, 1'b1, 16'h4001, 1'b0});
    tbl.push_back('{5'b00011, pd(0, 16'hC100) | pd(1, 16'h0002), 1'b1, 5'b00010, 1'b1, 16'h0002, 1'b0});
    tbl.push_back('{5'b00011, pd(0, 16'hC100) | pd(1, 16'h8003), 1'b1, 5'b00010, 1'b1, 16'h8003, 1'b0});
    tbl.push_back('{5'b00001, pd(0, 16'hC100), 1'b1, 5'b00001, 1'b1, 16'hC100, 1'b0});
    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: output full and not accepted, then one pop per cycle.
    for (int k = 0; k < 4; k++)
      run_vec('{5'b10000, pd(4, 16'hC440), 1'b0, 5'b00000, 1'b1, 16'hC100, 1'b0}, $sformatf("stall%0d", k));
    for (int k = 0; k < 3; k++)
      run_vec('{5'b10000, pd(4, 16'hC440 + 16'(k)), 1'b1, 5'b10000, 1'b1, 16'hC440 + 16'(k), 1'b0},
              $sformatf("drain%0d", k));

    // Stray BODY in IDLE is popped and dropped.
    run_vec('{5'b00000, '0, 1'b1, 5'b00000, 1'b0, 16'hC442, 1'b0}, "bubble");
    run_vec('{5'b00001, pd(0, 16'h0011), 1'b1, 5'b00001, 1'b0, 16'hC442, 1'b1}, "stray");
    run_vec('{5'b00000, '0, 1'b1, 5'b00000, 1'b0, 16'hC442, 1'b0}, "stray_end");

    // Reset after a HEAD: output clears at once, pointer restarts at 0, remainder is stray.
    run_vec('{5'b00100, pd(2, 16'h4200), 1'b1, 5'b00100, 1'b1, 16'h4200, 1'b0}, "mid_head");
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(out_valid), 32'h0);
    chk("mid_rst_shift", 32'(in_shift), 32'h0);
    tick();
    rst_n = 1'b1;
    run_vec('{5'b00011, pd(0, 16'hC000) | pd(1, 16'hC001), 1'b1, 5'b00001, 1'b1, 16'hC000, 1'b0}, "post_rst_rr");
    run_vec('{5'b00100, pd(2, 16'h0201), 1'b1, 5'b00100, 1'b0, 16'hC000, 1'b1}, "post_rst_body");

    // Random traffic against the reference model.
    rst_n = 1'b0;
    in_valid = '0;
    tick();
    rst_n = 1'b1;
    m_owner = -1; m_ptr = 0; m_vld = 1'b0; m_dat = '0; m_err = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      int g;
      logic [N-1:0] es;
      in_valid  = N'($urandom_range(0, (1 << N) - 1));
      for (int p = 0; p < N; p++) in_data[p*W +: W] = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      g  = m_grant();
      es = '0;
      if (g >= 0) es[g] = 1'b1;
      chk($sformatf("rnd%0d_shift", c), 32'(in_shift), 32'(es));
      m_step(g);
      tick();
      chk($sformatf("rnd%0d_vld", c), 32'(out_valid), 32'(m_vld));
      chk($sformatf("rnd%0d_dat", c), 32'(out_data), 32'(m_dat));
      chk($sformatf("rnd%0d_err", c), 32'(err_o), 32'(m_err));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
